// File: rtl/frame_buf_scheduler.sv
// rtl/frame_buf_scheduler.sv - triple-buffer frame scheduler granting writer and reader slots
module frame_buf_scheduler (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ctrl_enable,
  input  logic        ctrl_soft_reset,
  input  logic [31:0] buf_addr0,
  input  logic [31:0] buf_addr1,
  input  logic [31:0] buf_addr2,
  input  logic        wr_start,
  input  logic        wr_done,
  output logic        wr_grant,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_idx,
  input  logic        rd_req,
  input  logic        rd_done,
  output logic        rd_grant,
  output logic [31:0] rd_addr,
  output logic [1:0]  rd_idx,
  output logic [1:0]  buf_idx,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        evt_frame_done,
  output logic        evt_error
);

  typedef enum logic {W_IDLE, W_ACTIVE} wr_state_t;
  typedef enum logic {R_IDLE, R_ACTIVE} rd_state_t;

  wr_state_t  wr_state, wr_state_nxt;
  rd_state_t  rd_state, rd_state_nxt;

  // W, L and R always hold a permutation of {0,1,2}
  logic [1:0] w_slot, l_slot, r_slot;
  logic       l_valid;

  logic        clr;
  logic        wr_go, wr_fin, rd_want, rd_go, drop_inc, err;
  logic [31:0] w_addr_sel, l_addr_sel;

  assign clr = areset | ctrl_soft_reset;

  // base address of the writer slot and of the latest slot
  always_comb begin
    w_addr_sel = 32'h0;
    l_addr_sel = 32'h0;
    case (w_slot)
      2'd0:    w_addr_sel = buf_addr0;
      2'd1:    w_addr_sel = buf_addr1;
      2'd2:    w_addr_sel = buf_addr2;
      default: w_addr_sel = 32'h0;
    endcase
    case (l_slot)
      2'd0:    l_addr_sel = buf_addr0;
      2'd1:    l_addr_sel = buf_addr1;
      2'd2:    l_addr_sel = buf_addr2;
      default: l_addr_sel = 32'h0;
    endcase
  end

  // next state and per-cycle actions; a finishing write defers a read grant by one cycle
  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    wr_go        = 1'b0;
    wr_fin       = 1'b0;
    rd_go        = 1'b0;
    rd_want      = (rd_state == R_IDLE) && rd_req && l_valid && ctrl_enable;
    case (wr_state)
      W_IDLE: begin
        if (wr_start && ctrl_enable) begin
          wr_go        = 1'b1;
          wr_state_nxt = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (wr_done) begin
          wr_fin       = 1'b1;
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE: begin
        if (rd_want && !wr_fin) begin
          rd_go        = 1'b1;
          rd_state_nxt = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rd_done) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
    // an overwrite that a waiting reader is about to pick up is not a drop
    drop_inc = wr_fin && l_valid && !rd_want;
    err      = (wr_done && (wr_state == W_IDLE)) || (rd_done && (rd_state == R_IDLE));
  end

  // FSM state registers
  always_ff @(posedge aclk) begin
    if (clr) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // slot rotation, latched grant addresses, counters and event pulses
  always_ff @(posedge aclk) begin
    if (clr) begin
      w_slot         <= 2'd0;
      l_slot         <= 2'd1;
      r_slot         <= 2'd2;
      l_valid        <= 1'b0;
      wr_grant       <= 1'b0;
      wr_addr        <= 32'h0;
      wr_idx         <= 2'd0;
      rd_grant       <= 1'b0;
      rd_addr        <= 32'h0;
      rd_idx         <= 2'd2;
      buf_idx        <= 2'd0;
      frame_cnt      <= 16'h0;
      drop_cnt       <= 16'h0;
      evt_frame_done <= 1'b0;
      evt_error      <= 1'b0;
    end else begin
      wr_grant       <= wr_go;
      rd_grant       <= rd_go;
      evt_frame_done <= wr_fin;
      evt_error      <= err;
      if (wr_go) begin
        wr_addr <= w_addr_sel;
        wr_idx  <= w_slot;
      end
      if (wr_fin) begin
        w_slot    <= l_slot;
        l_slot    <= w_slot;
        l_valid   <= 1'b1;
        buf_idx   <= w_slot;
        frame_cnt <= frame_cnt + 16'd1;
        if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
      if (rd_go) begin
        r_slot  <= l_slot;
        l_slot  <= r_slot;
        l_valid <= 1'b0;
        rd_addr <= l_addr_sel;
        rd_idx  <= l_slot;
      end
    end
  end

endmodule

// File: doc/frame_buf_scheduler.md
FRAME_BUF_SCHEDULER -- requirements
Module: frame_buf_scheduler

Interface
REQ-001 SHALL have port aclk, input, 1, single clock for all logic.
REQ-002 SHALL have port areset, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have ports ctrl_enable and ctrl_soft_reset, input, 1 each; grant enable and synchronous state clear (from CONTROL[0] and CONTROL[1]).
REQ-004 SHALL have ports buf_addr0, buf_addr1 and buf_addr2, input, 32 each; frame buffer base addresses from BUF_ADDR0..2.
REQ-005 SHALL have writer ports wr_start (in, 1), wr_done (in, 1), wr_grant (out, 1), wr_addr (out, 32) and wr_idx (out, 2).
REQ-006 SHALL have reader ports rd_req (in, 1, level), rd_done (in, 1), rd_grant (out, 1), rd_addr (out, 32) and rd_idx (out, 2).
REQ-007 SHALL have status ports buf_idx (out, 2, last completed buffer, drives BUF_IDX), frame_cnt (out, 16) and drop_cnt (out, 16).
REQ-008 SHALL have event ports evt_frame_done (out, 1) and evt_error (out, 1); single-cycle pulses feeding IRQ_STATUS bits 0 and 1.

Function
REQ-009 SHALL hold three 2-bit slot registers W (writer), L (latest) and R (reader); {W,L,R} is always a permutation of {0,1,2}.
REQ-010 SHALL hold a 1-bit l_valid flag; when set, L holds a completed frame that has not been read.
REQ-011 SHALL run a writer FSM with states W_IDLE and W_ACTIVE.
REQ-012 SHALL run a reader FSM with states R_IDLE and R_ACTIVE.
REQ-013 SHALL, in W_IDLE with wr_start=1 and ctrl_enable=1 at cycle N, go to W_ACTIVE and at N+1 pulse wr_grant for 1 cycle, with wr_addr=buf_addr[W] and wr_idx=W latched and held until the next grant.
REQ-014 SHALL ignore wr_start while in W_ACTIVE.
REQ-015 SHALL, on wr_done=1 in W_ACTIVE, swap W and L, set l_valid=1, set buf_idx to the finished index, increment frame_cnt (wrapping at 16 bits), pulse evt_frame_done next cycle, and return to W_IDLE.
REQ-016 SHALL, if l_valid was already 1 at that wr_done, increment drop_cnt, saturating at 0xFFFF.
REQ-017 SHALL, in R_IDLE with rd_req=1, l_valid=1 and ctrl_enable=1, swap R and L, clear l_valid, go to R_ACTIVE, and next cycle pulse rd_grant for 1 cycle with rd_addr=buf_addr[new R] and rd_idx=new R, both held.
REQ-018 SHALL, on rd_done=1 in R_ACTIVE, return to R_IDLE; the R slot then stays reserved until the next read grant.
REQ-019 SHALL give the writer swap priority when wr_done and a read-grant condition occur in the same cycle: the read grant is deferred exactly one cycle and then takes the newly completed frame, with no drop counted.
REQ-020 SHALL pulse evt_error for 1 cycle, one cycle after wr_done in W_IDLE or rd_done in R_IDLE; state is unchanged otherwise.
REQ-021 SHALL, when ctrl_enable=0, issue no new grants while active transfers still complete normally on wr_done/rd_done.
REQ-022 SHALL sample buf_addrN only at grant time; later register writes do not alter a granted address.
REQ-023 SHALL keep wr_start and rd_req simultaneous grants independent; both may grant in the same cycle.

Reset
REQ-024 SHALL, on areset=1 or ctrl_soft_reset=1 (synchronous, soft reset identical to hard reset, abandoning any transfer in progress), set W=0, L=1, R=2, l_valid=0, both FSMs IDLE, wr_idx=0, rd_idx=2, buf_idx=0, wr_addr=rd_addr=0, frame_cnt=drop_cnt=0, and all grant/evt outputs to 0.
REQ-025 SHALL give reset priority over all simultaneous wr_done, rd_done, wr_start and rd_req inputs.

Verification
REQ-026 Basic: buf_addr0/1/2=0x1000_0000/0x1040_0000/0x1080_0000, wr_start -> wr_grant, wr_addr=0x1000_0000; wr_done -> evt_frame_done, buf_idx=0, frame_cnt=1; rd_req -> rd_grant, rd_addr=0x1000_0000, rd_idx=0.
REQ-027 Drop: three write frames with no reader -> frame_cnt=3, drop_cnt=2, and wr_idx sequence 0,1,0 (W/L ping-pong while R=2 is held).
REQ-028 Collision: rd_req held with l_valid=0 and wr_done -> rd_grant exactly 2 cycles after wr_done, granting the just-finished index, drop_cnt=0.
REQ-029 Error: rd_done in R_IDLE -> one evt_error pulse, with R, L, W and l_valid unchanged.
REQ-030 Reset mid-transfer: ctrl_soft_reset pulse during W_ACTIVE and R_ACTIVE -> W=0, L=1, R=2, counters 0; a later wr_done -> evt_error.
REQ-031 Permutation check: random stimulus over 10^5 cycles -> {W,L,R} stays a permutation every cycle, and drop_cnt saturates at 0xFFFF when forced.
